// File: rtl/synth_pkg.sv
// Shared types and defaults for the note phase accumulator.
// Holds the note state encoding, default datapath widths and the gain ceiling.
// Optional build macro used by this slice: ATTACK_RAMP_EN.
package synth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_PLAY    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } note_state_t;

  localparam int DEF_PHASE_WIDTH = 24;
  localparam int DEF_GAIN_WIDTH  = 8;
  localparam int DEF_GAIN_MAX    = (1 << DEF_GAIN_WIDTH) - 1;

endpackage

// File: rtl/note_phase_accum_if.sv
// Sample bus toward the sample buffer: phase plus envelope gain.
// Valid/ready handshake; a sample transfers on a cycle with valid && ready.
// The producer holds phase and gain stable while valid && !ready.
interface note_phase_accum_if
  import synth_pkg::*;
#(
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int GAIN_WIDTH  = DEF_GAIN_WIDTH
);
  logic                   valid;
  logic                   ready;
  logic [PHASE_WIDTH-1:0] accumulated_value;
  logic [GAIN_WIDTH-1:0]  env_gain;

  modport master (output valid, output accumulated_value, output env_gain, input ready);
  modport slave  (input valid, input accumulated_value, input env_gain, output ready);
endinterface

// File: rtl/note_phase_accum_sample_step_counter.sv
// Counts accepted samples modulo STEP_SAMPLES; step pulses on the wrapping accept.
// Latency: step is combinational with the accept that completes a period.
// No backpressure: inc is the accepted-sample strobe, clr has priority.
module sample_step_counter #(
  parameter int STEP_SAMPLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic step
);

  localparam int CW = (STEP_SAMPLES > 1) ? $clog2(STEP_SAMPLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_SAMPLES - 1);

  logic [CW-1:0] cnt_q;

  assign step = inc && !clr && (cnt_q == LAST);

  // Sample counter: cleared on request or when a full period completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr || step) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/note_phase_accum.sv
// Phase accumulator with note lifecycle FSM and stepped release envelope.
// Latency: pulses and accepts take effect on the next edge; all outputs registered.
// Backpressure: phase and gain advance only on valid && ready; release stalls while ready=0.
// Optional build macro: ATTACK_RAMP_EN inserts a linear gain attack ahead of PLAY.
module note_phase_accum
  import synth_pkg::*;
#(
  parameter int PHASE_WIDTH  = DEF_PHASE_WIDTH,
  parameter int GAIN_WIDTH   = DEF_GAIN_WIDTH,
  parameter int STEP_SAMPLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PHASE_WIDTH-1:0] fcw,
  input  logic                   note_start,
  input  logic                   note_release,
  input  logic                   note_reset,
  output logic                   note_active,
  output logic                   note_finished,
  note_phase_accum_if.master     smp
);

  localparam logic [GAIN_WIDTH-1:0] GAIN_MAX = '1;

  note_state_t            state_q, state_n;
  logic [PHASE_WIDTH-1:0] phase_q, phase_n;
  logic [GAIN_WIDTH-1:0]  gain_q, gain_n;
  logic                   valid_q, finished_q;

  logic accept;
  logic release_hit;
  logic pulse;
  logic env_running;
  logic cnt_clr;
  logic cnt_inc;
  logic step;

  assign accept = valid_q && smp.ready;

`ifdef ATTACK_RAMP_EN
  assign release_hit = note_release && (state_q == ST_PLAY || state_q == ST_ATTACK);
  assign env_running = (state_q == ST_RELEASE) || (state_q == ST_ATTACK);
`else
  assign release_hit = note_release && (state_q == ST_PLAY);
  assign env_running = (state_q == ST_RELEASE);
`endif

  // An ignored release is not a pulse, so it does not block the handshake update.
  assign pulse   = note_reset || note_start || release_hit;
  assign cnt_clr = pulse;
  assign cnt_inc = accept && !pulse && env_running;

  sample_step_counter #(
    .STEP_SAMPLES (STEP_SAMPLES)
  ) u_step (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .step (step)
  );

  // Next state: pulses by priority, otherwise advance on an accepted sample.
  always_comb begin
    state_n = state_q;
    phase_n = phase_q;
    gain_n  = gain_q;
    if (note_reset) begin
      state_n = ST_IDLE;
      phase_n = '0;
      gain_n  = '0;
    end else if (note_start) begin
      phase_n = '0;
`ifdef ATTACK_RAMP_EN
      state_n = ST_ATTACK;
      gain_n  = '0;
`else
      state_n = ST_PLAY;
      gain_n  = GAIN_MAX;
`endif
    end else if (release_hit) begin
      state_n = ST_RELEASE;
    end else if (accept) begin
      phase_n = phase_q + fcw;
      if (state_q == ST_RELEASE && step) begin
        // A release entered at gain 0 (possible from an early attack) also ends here.
        if (gain_q <= GAIN_WIDTH'(1)) begin
          state_n = ST_DONE;
          gain_n  = '0;
        end else begin
          gain_n = gain_q - GAIN_WIDTH'(1);
        end
      end
`ifdef ATTACK_RAMP_EN
      if (state_q == ST_ATTACK && step) begin
        gain_n = gain_q + GAIN_WIDTH'(1);
        if (gain_q == GAIN_MAX - GAIN_WIDTH'(1)) begin
          state_n = ST_PLAY;
        end
      end
`endif
    end
  end

  // State and registered outputs, flags decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      gain_q     <= '0;
      valid_q    <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      phase_q    <= phase_n;
      gain_q     <= gain_n;
      valid_q    <= (state_n == ST_PLAY) || (state_n == ST_RELEASE) || (state_n == ST_ATTACK);
      finished_q <= (state_n == ST_DONE);
    end
  end

  assign smp.valid             = valid_q;
  assign smp.accumulated_value = phase_q;
  assign smp.env_gain          = gain_q;
  assign note_active           = valid_q;
  assign note_finished         = finished_q;

endmodule

// File: doc/note_phase_accum.md
Name: note_phase_accum

Overview:
- Upstream stage of the synth signal chain: converts the CPU-written 24-bit frequency control word into a running phase for the NCO scaler/summer.
- Tracks per-note lifecycle (start/release/reset pulses decoded from the memory map) and produces an 8-bit envelope gain plus the note_finished status bit read back at 0x100c.
- Output side is a ready/valid handshake toward the sample buffer; the phase advances only on accepted samples.

Parameters:
- PHASE_WIDTH, 24, accumulator and fcw width
- GAIN_WIDTH, 8, envelope gain width
- STEP_SAMPLES, 64, accepted samples per envelope gain step (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- fcw  in  PHASE_WIDTH  frequency control word, live register value
- note_start  in  1  single-cycle pulse
- note_release  in  1  single-cycle pulse
- note_reset  in  1  single-cycle pulse
- ready  in  1  downstream accepts sample
- valid  out  1  sample available
- accumulated_value  out  PHASE_WIDTH  current phase
- env_gain  out  GAIN_WIDTH  envelope gain, 0..2^GAIN_WIDTH-1
- note_active  out  1  state is PLAY or RELEASE
- note_finished  out  1  state is DONE

Behaviour:
- Reset (rst=0, async): state IDLE, accumulated_value=0, env_gain=0, valid=0, note_active=0, note_finished=0, step counter=0.
- States: IDLE, PLAY, RELEASE, DONE; all outputs registered.
- valid=1 in PLAY and RELEASE, 0 in IDLE and DONE. accumulated_value and env_gain are held stable while valid&&!ready.
- Handshake: on a clock edge with valid&&ready, accumulated_value <= accumulated_value + fcw, modulo 2^PHASE_WIDTH. Wrap-around is silent. fcw is sampled at that edge, so pitch changes take effect on the next accepted sample.
- Pulse priority, same cycle: note_reset > note_start > note_release. A pulse takes effect one cycle later and overrides any handshake update in that cycle.
- note_reset, any state -> IDLE: phase=0, gain=0, counter=0, note_finished=0.
- note_start, any state -> PLAY: phase=0, gain=max (255), counter=0. Restarting from PLAY, RELEASE or DONE is legal.
- note_release:
  - in PLAY -> RELEASE, counter=0.
  - ignored in IDLE, RELEASE and DONE.
- RELEASE: the step counter increments per accepted sample. When it reaches STEP_SAMPLES-1 on an accept, it clears and gain decrements by 1. When gain would go from 1 to 0, the state becomes DONE with gain=0 on the same edge.
- DONE: note_finished=1, held until note_start or note_reset. Phase is frozen.
- Total release length: 255*STEP_SAMPLES accepted samples. With ready held low, the release stalls indefinitely, with no time-based decay.
- Asserting rst mid-note aborts immediately to the reset values. Recovery requires a new note_start.

Optional Feature:
- Macro ATTACK_RAMP_EN.
- When defined: an ATTACK state is inserted. note_start enters ATTACK with gain=0. Gain increments by 1 every STEP_SAMPLES accepted samples. On reaching max it moves to PLAY. note_release in ATTACK -> RELEASE from the current gain. In ATTACK, valid=1 and note_active=1.
- When undefined: note_start jumps directly to PLAY with gain=max. The ATTACK state and its logic are absent.

Decomposition:
- Shared package synth_pkg holds:
  - the note state enum (IDLE/ATTACK/PLAY/RELEASE/DONE, 3-bit encoding)
  - PHASE_WIDTH and GAIN_WIDTH default constants
  - gain max constant
- One sub-module, sample_step_counter: counts accepted samples modulo STEP_SAMPLES, with a synchronous clear, and emits a one-cycle step pulse.

Test Plan:
- Reset, then note_start, fcw=0x000100, ready=1 -> valid=1 next cycle; phase 0x000000, 0x000100, 0x000200… per cycle; env_gain=255; note_active=1.
- fcw=0x800001, start, ready=1 for 3 accepts -> phase 0x000000, 0x800001, 0x000002 (wrap); no flags change.
- STEP_SAMPLES=4, PLAY then note_release, ready=1 -> gain 254 after 4 accepts; DONE and note_finished=1 after 1020 accepts; valid=0; phase frozen.
- ready toggled 0/1 every cycle during PLAY -> phase increments only on ready=1 cycles; outputs stable while ready=0.
- note_reset and note_start in the same cycle while in RELEASE -> IDLE, gain=0, valid=0; a later note_start alone -> PLAY, gain=255.
- rst driven low asynchronously mid-release, between clock edges -> all outputs 0 immediately; after rst returns high, state stays IDLE until note_start.
